mem_dump: RTL and testbench

MEM_DUMP -- requirements
Module: mem_dump

---
 rtl/mem_dump.sv | 154 +++++++++++++++
 tb/tb_mem_dump.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump.sv
// Memory dump engine: streams a contiguous (wrapping) address range out of a
// synchronous-read memory through a 2-entry FIFO and keeps a 16-bit running checksum.
module mem_dump #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [8:0]        length,
  output logic              mem_active,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } stateT;

  stateT             state;
  logic [ADDR_W-1:0] readPtr;
  logic [8:0]        readCount;
  logic [8:0]        xferCount;

  logic              inFlight;
  logic [ADDR_W-1:0] flightAddr;

  logic [DATA_W-1:0] fifoData [2];
  logic [ADDR_W-1:0] fifoAddr [2];
  logic              wrIdx;
  logic              rdIdx;
  logic [1:0]        fifoCount;

  logic              push;
  logic              pop;
  logic [2:0]        pending;

  assign out_valid  = (fifoCount != 2'd0);
  assign out_data   = fifoData[rdIdx];
  assign out_addr   = fifoAddr[rdIdx];
  assign pop        = out_valid & out_ready;
  assign push       = inFlight;
  assign mem_addr   = readPtr;
  assign mem_active = busy;

  // Credit counts the word leaving this cycle as already gone, so a steady
  // consumer sees one word per cycle while the FIFO still never exceeds two.
  assign pending = {1'b0, fifoCount} + {2'b00, inFlight} - {2'b00, pop};

  always_comb begin
    mem_re = 1'b0;
    if (state == RUN && readCount != 9'd0 && pending < 3'd2)
      mem_re = 1'b1;
  end

  // Read pipeline: the memory returns data one cycle after mem_re, so the
  // address of the outstanding read travels alongside it into the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inFlight   <= 1'b0;
      flightAddr <= '0;
    end else begin
      inFlight <= mem_re;
      if (mem_re)
        flightAddr <= readPtr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        fifoData[i] <= '0;
        fifoAddr[i] <= '0;
      end
      wrIdx     <= 1'b0;
      rdIdx     <= 1'b0;
      fifoCount <= 2'd0;
    end else begin
      if (push) begin
        fifoData[wrIdx] <= mem_dout;
        fifoAddr[wrIdx] <= flightAddr;
        wrIdx           <= ~wrIdx;
      end
      if (pop)
        rdIdx <= ~rdIdx;
      fifoCount <= fifoCount + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      readPtr   <= '0;
      readCount <= 9'd0;
      xferCount <= 9'd0;
      checksum  <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            checksum <= 16'h0000;
            if (length == 9'd0) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              readPtr   <= base_addr;
              readCount <= length;
              xferCount <= length;
              busy      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mem_re) begin
            readPtr   <= readPtr + ADDR_W'(1);
            readCount <= readCount - 9'd1;
            if (readCount == 9'd1)
              state <= FLUSH;
          end
        end
        FLUSH: begin
        end
        default: state <= IDLE;
      endcase

      // The last word can only leave after its read was issued two edges
      // earlier, so this always lands in FLUSH and safely overrides the case.
      if (state != IDLE && pop) begin
        checksum  <= checksum + 16'(out_data);
        xferCount <= xferCount - 9'd1;
        if (xferCount == 9'd1) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_dump.sv
// Randomized self-checking bench for mem_dump: a queue-based reference model
// predicts the word sequence and checksum of each dump from the memory image.
module tb_mem_dump;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        mem_active;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [15:0] mem_dout = 16'h0000;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_addr;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  mem_dump #(.ADDR_W(8), .DATA_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .mem_active(mem_active), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clock = ~clock;

  logic [15:0] memArr [256];
  always @(posedge clock) if (mem_re) mem_dout <= memArr[mem_addr];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [23:0] gotQ [$];
  logic [23:0] heldWord;
  bit holdPend;
  int firstValid, doneCount, doneCyc, lastXferCyc, gaps, issued, maxOut;
  int badRe, stableErr, startEdgeCyc, busyAfterStart, busyAtDone;

  // Observe the DUT mid-cycle, when everything for the coming edge is settled.
  always @(negedge clock) begin
    if (reset) begin
      if (issued - gotQ.size() > maxOut) maxOut = issued - gotQ.size();
      if (holdPend && (!out_valid || {out_addr, out_data} != heldWord)) stableErr++;
      holdPend = out_valid && !out_ready;
      heldWord = {out_addr, out_data};
      if (out_valid && firstValid < 0) firstValid = cyc;
      if (cyc == startEdgeCyc) busyAfterStart = busy;
      if (mem_re) begin
        issued++;
        if (!busy) badRe++;
      end
      if (out_valid && out_ready) begin
        if (gotQ.size() > 0 && cyc != lastXferCyc + 1) gaps++;
        gotQ.push_back({out_addr, out_data});
        lastXferCyc = cyc;
      end
      if (done) begin
        doneCount++;
        doneCyc    = cyc;
        busyAtDone = busy;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearMonitor();
    gotQ.delete();
    holdPend = 0; firstValid = -1; doneCount = 0; doneCyc = -1; lastXferCyc = -1;
    gaps = 0; issued = 0; maxOut = 0; badRe = 0; stableErr = 0;
    startEdgeCyc = -10; busyAfterStart = -1; busyAtDone = -1;
  endtask

  // readyMode: 0 = always ready, 1 = toggle 1/0 each cycle, 2 = random.
  task automatic applyStimulus(input logic [7:0] base, input logic [8:0] len,
                               input int readyMode, input bit rePulse);
    logic [23:0] expQ [$];
    logic [15:0] expSum = 16'h0000;
    logic [7:0]  a;
    for (int i = 0; i < int'(len); i++) begin
      a = 8'((int'(base) + i) % 256);
      expQ.push_back({a, memArr[a]});
      expSum = expSum + memArr[a];
    end
    clearMonitor();
    @(posedge clock); #1;
    start = 1'b1; base_addr = base; length = len;
    startEdgeCyc = cyc + 1;
    out_ready = (readyMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      start     = rePulse && (i == 2);
      base_addr = (rePulse && i == 2) ? 8'h80 : base;
      if (readyMode == 0) out_ready = 1'b1;
      else if (readyMode == 1) out_ready = ~out_ready;
      else out_ready = 1'($urandom_range(0, 1));
      if (doneCount != 0) break;
    end
    start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    checkOutput("done_count", doneCount, 1);
    checkOutput("reads_issued", issued, len);
    checkOutput("checksum", checksum, expSum);
    checkOutput("mem_active_idle", mem_active, 0);
    checkOutput("busy_idle", busy, 0);
    checkOutput("bad_re", badRe, 0);
    if (len == 9'd0) begin
      checkOutput("zero_done_timing", doneCyc - startEdgeCyc, 0);
      checkOutput("zero_no_valid", firstValid, -1);
      checkOutput("zero_not_busy", busyAfterStart, 0);
    end else begin
      checkOutput("xfer_count", gotQ.size(), len);
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
        checkOutput($sformatf("word%0d", i), gotQ[i], expQ[i]);
      checkOutput("first_valid_latency", firstValid - startEdgeCyc, 2);
      checkOutput("busy_on_start", busyAfterStart, 1);
      checkOutput("done_after_last", doneCyc - lastXferCyc, 1);
      checkOutput("busy_at_done", busyAtDone, 0);
      checkOutput("buffered_le2", maxOut <= 2, 1);
      checkOutput("stable_hold", stableErr, 0);
      if (readyMode == 0) checkOutput("gaps", gaps, 0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) memArr[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) memArr[i] = 16'h1121;
    clearMonitor();
    #1;
    checkOutput("reset_ctrl", {mem_active, mem_re, out_valid, busy, done}, 5'b0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    checkOutput("reset_out", {out_addr, out_data}, 0);
    checkOutput("reset_checksum", checksum, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    $display("[TB] basic length-5 dump");
    applyStimulus(8'h00, 9'd5, 0, 1'b0);
    checkOutput("basic_sum", checksum, 16'h55A5);

    $display("[TB] toggling out_ready");
    applyStimulus(8'h00, 9'd5, 1, 1'b0);
    checkOutput("toggle_sum", checksum, 16'h55A5);

    $display("[TB] address wrap");
    memArr[8'hFE] = 16'h0001; memArr[8'hFF] = 16'h0002; memArr[8'h00] = 16'h0003;
    applyStimulus(8'hFE, 9'd3, 0, 1'b0);
    checkOutput("wrap_sum", checksum, 16'h0006);

    $display("[TB] zero length");
    applyStimulus(8'h10, 9'd0, 0, 1'b0);
    checkOutput("zero_sum", checksum, 16'h0000);

    $display("[TB] reset mid-dump");
    memArr[8'h00] = 16'h1121;
    clearMonitor();
    @(posedge clock); #1;
    start = 1'b1; base_addr = 8'h00; length = 9'd5; out_ready = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int i = 0; i < 50 && gotQ.size() < 2; i++) @(posedge clock);
    checkOutput("abort_two_xfers", gotQ.size(), 2);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_ctrl", {mem_active, mem_re, out_valid, busy, done}, 5'b0);
    checkOutput("abort_mem_addr", mem_addr, 0);
    checkOutput("abort_out", {out_addr, out_data}, 0);
    checkOutput("abort_checksum", checksum, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 checkOutput("abort_no_done", doneCount, 0);
    applyStimulus(8'h00, 9'd5, 0, 1'b0);
    checkOutput("restart_sum", checksum, 16'h55A5);

    $display("[TB] start ignored while busy");
    applyStimulus(8'h00, 9'd5, 0, 1'b1);

    $display("[TB] randomized dumps");
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) memArr[i] = 16'($urandom);
      applyStimulus(8'($urandom_range(0, 255)),
                    (t == 0) ? 9'd300 : 9'($urandom_range(1, 24)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
